// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the elastic inter-stage pipeline buffer:
// reset PC, bubble instruction and sideband tag bit positions.
package pipe_stage_buf_pkg;

    localparam logic [31:0] PC_START  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    // Bit positions inside the sideband tag
    localparam int TAG_EXC        = 0;
    localparam int TAG_BD         = 1;
    localparam int TAG_PRED_TAKEN = 2;

    typedef enum logic {
        SLOT_MAIN = 1'b0,
        SLOT_SKID = 1'b1
    } slot_id_e;

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One entry register (valid + PC + instruction + tag) with clear, load and
// unload controls; clear restores the reset contents.
module pipe_slot
    import pipe_stage_buf_pkg::*;
#(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 TAG_W     = 8,
    parameter logic [PC_W-1:0]    PC_RESET  = pipe_stage_buf_pkg::PC_START,
    parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_stage_buf_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic               unload,
    input  logic [PC_W-1:0]    d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [TAG_W-1:0]   d_tag,
    output logic               v,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [TAG_W-1:0]   tag
);

    logic               v_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [TAG_W-1:0]   tag_reg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            v_reg     <= 1'b0;
            pc_reg    <= PC_RESET;
            instr_reg <= NOP_INSTR;
            tag_reg   <= '0;
        end else if (load) begin
            v_reg     <= 1'b1;
            pc_reg    <= d_pc;
            instr_reg <= d_instr;
            tag_reg   <= d_tag;
        end else if (unload) begin
            // Payload is left in place; consumers gate it with v.
            v_reg     <= 1'b0;
        end
    end

    assign v     = v_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;
    assign tag   = tag_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register: main + skid slot, valid/ready handshake with a
// registered in_ready, flush-to-bubble and saturating stall/flush counters.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 TAG_W     = 8,
    parameter logic [PC_W-1:0]    PC_RESET  = pipe_stage_buf_pkg::PC_START,
    parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_stage_buf_pkg::NOP_INSTR,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic               slot_v     [2];
    logic [PC_W-1:0]    slot_pc    [2];
    logic [INSTR_W-1:0] slot_instr [2];
    logic [TAG_W-1:0]   slot_tag   [2];
    logic               slot_load  [2];
    logic               slot_unload[2];
    logic [PC_W-1:0]    slot_d_pc   [2];
    logic [INSTR_W-1:0] slot_d_instr[2];
    logic [TAG_W-1:0]   slot_d_tag  [2];

    logic main_v, skid_v;
    logic accept, pop, promote;

    assign main_v = slot_v[SLOT_MAIN];
    assign skid_v = slot_v[SLOT_SKID];

    // skid_v is a register, so in_ready is registered as well
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign accept    = in_valid && in_ready;
    assign pop       = main_v && out_ready;
    assign promote   = pop && skid_v;

    always_comb begin
        slot_load[SLOT_MAIN]    = 1'b0;
        slot_unload[SLOT_MAIN]  = 1'b0;
        slot_load[SLOT_SKID]    = 1'b0;
        slot_unload[SLOT_SKID]  = 1'b0;
        slot_d_pc[SLOT_MAIN]    = in_pc;
        slot_d_instr[SLOT_MAIN] = in_instr;
        slot_d_tag[SLOT_MAIN]   = in_tag;
        slot_d_pc[SLOT_SKID]    = in_pc;
        slot_d_instr[SLOT_SKID] = in_instr;
        slot_d_tag[SLOT_SKID]   = in_tag;

        if (!main_v) begin
            slot_load[SLOT_MAIN] = accept;
        end else if (pop) begin
            if (skid_v) begin
                slot_load[SLOT_MAIN]    = 1'b1;
                slot_d_pc[SLOT_MAIN]    = slot_pc[SLOT_SKID];
                slot_d_instr[SLOT_MAIN] = slot_instr[SLOT_SKID];
                slot_d_tag[SLOT_MAIN]   = slot_tag[SLOT_SKID];
                slot_unload[SLOT_SKID]  = 1'b1;
            end else if (accept) begin
                slot_load[SLOT_MAIN]    = 1'b1;
            end else begin
                slot_unload[SLOT_MAIN]  = 1'b1;
            end
        end else begin
            slot_load[SLOT_SKID] = accept;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            pipe_slot #(
                .PC_W      (PC_W),
                .INSTR_W   (INSTR_W),
                .TAG_W     (TAG_W),
                .PC_RESET  (PC_RESET),
                .NOP_INSTR (NOP_INSTR)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .clear   (flush),
                .load    (slot_load[gi]),
                .unload  (slot_unload[gi]),
                .d_pc    (slot_d_pc[gi]),
                .d_instr (slot_d_instr[gi]),
                .d_tag   (slot_d_tag[gi]),
                .v       (slot_v[gi]),
                .pc      (slot_pc[gi]),
                .instr   (slot_instr[gi]),
                .tag     (slot_tag[gi])
            );
        end
    endgenerate

    assign out_pc    = slot_pc[SLOT_MAIN];
    assign out_instr = main_v ? slot_instr[SLOT_MAIN] : NOP_INSTR;
    assign out_tag   = main_v ? slot_tag[SLOT_MAIN] : '0;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    // Statistics: both counters saturate at all-ones
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic [1:0]       flush_add;
    logic [CNT_W:0]   flush_sum;

    // A popped head was seen downstream, so it is not counted as flushed
    assign flush_add = {1'b0, main_v && !pop} + {1'b0, skid_v};
    assign flush_sum = {1'b0, flush_cnt_reg} + {{(CNT_W-1){1'b0}}, flush_add};

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (main_v && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
        if (flush) begin
            flush_cnt_next = flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised, elastic inter-stage pipeline register for the pipelined MIPS core. Generalises the fixed IF/ID latch.
- Carries PC, instruction word and a sideband tag between any two stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput with a registered in_ready), flush-to-bubble, and saturating stall/flush statistics counters.
- Instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB. Each stage keeps its own combinational decoder on out_instr.

Parameters:
- PC_W, 32, width of PC field
- INSTR_W, 32, width of instruction field
- TAG_W, 8, sideband width (exception/branch-predict bits); minimum 1
- PC_RESET, 32'h0000_3000, PC value held after reset and flush
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0)
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  upstream entry present
- in_ready  out  1  buffer can accept; driven from a register
- in_pc  in  PC_W  upstream PC
- in_instr  in  INSTR_W  upstream instruction
- in_tag  in  TAG_W  upstream sideband
- out_valid  out  1  head entry present
- out_ready  in  1  downstream consumes head
- out_pc  out  PC_W  head PC
- out_instr  out  INSTR_W  head instruction; NOP_INSTR when out_valid=0
- out_tag  out  TAG_W  head sideband; 0 when out_valid=0
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- flush_cnt  out  CNT_W  valid entries discarded by flush

Behaviour:
- Storage: two slots, main (drives outputs) and skid. Each slot has v, pc, instr, tag.
- Handshake terms:
  - accept = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = !skid.v
  - out_valid = main.v
- Reset (reset=0 at a clock edge):
  - both slots: v=0, pc=PC_RESET, instr=NOP_INSTR, tag=0
  - counters = 0
  - after that edge: in_ready=1, out_valid=0, out_pc=PC_RESET, out_instr=NOP_INSTR, occupancy=0
  - reset overrides flush and the handshake
- Flush (reset=1, flush=1):
  - both slots cleared to the reset contents
  - an accept in the same cycle is dropped
  - a pop in the same cycle still completes: downstream sampled the head, and it is not counted as flushed
  - flush_cnt += number of valid slots not popped that cycle, saturating at all-ones
- Normal operation (reset=1, flush=0), by state:
  - main empty: accept loads main. Skid is empty by invariant.
  - main full, pop, skid empty: accept loads main; no accept empties main.
  - main full, pop, skid full: skid moves to main, skid.v=0. in_ready was 0, so there is no accept.
  - main full, no pop: accept loads skid.
- Invariants:
  - skid.v implies main.v
  - FIFO order preserved
  - no entry duplicated or lost except by flush
- Timing:
  - latency from in to out is 1 cycle when empty
  - throughput is 1 entry/cycle under continuous out_ready
  - in_ready deasserts the cycle after the skid fills and reasserts the cycle after it drains
- Outputs while out_valid=1 and out_ready=0 stay stable until pop.
- occupancy = main.v + skid.v.
- stall_cnt increments every cycle with out_valid & !out_ready, including a flush cycle, and saturates.
- in_* signals are ignored when in_valid=0. Behaviour with X on in_* while in_valid=0 must not corrupt state.

Decomposition:
- Shared package/header holds PC_START (32'h0000_3000), NOP_INSTR, and the tag bit assignments (TAG_EXC, TAG_BD, TAG_PRED_TAKEN).
- Natural sub-module: pipe_slot, one entry register with load/clear controls. It is instantiated twice (main, skid).
- The saturating counter is a small function or inline logic; no separate module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_pc=32'h0000_3000, out_instr=0, occupancy=0, counters 0, in_ready=1 the cycle after release.
- Streaming:
  - stimulus: out_ready=1, present pc=0x3000,0x3004,0x3008 with instr 0x24010001,0x24020002,0x00221820 on consecutive cycles
  - response: each appears on out_* exactly 1 cycle later, in order; in_ready stays 1; stall_cnt=0
- Backpressure:
  - stimulus: out_ready=0, push A then B
  - response: occupancy=2, in_ready=0, out_pc=A held
  - stimulus: raise out_ready
  - response: A then B emitted on consecutive cycles, in_ready=1 again; stall_cnt equals stalled cycles
- Flush mid-operation:
  - stimulus: 2 entries held, flush=1 with in_valid=1 and out_ready=0
  - response: next cycle out_valid=0, out_instr=0, incoming entry dropped, flush_cnt=2
  - repeat with out_ready=1: flush_cnt += 1
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Random: random in_valid/out_ready/flush for 10k cycles against a queue scoreboard -> ordering, invariants, and occupancy match every cycle.
